pll_lock_supervisor: RTL
========================

// Module: pll_lock_supervisor
// PURPOSE
//  Controls the reset of the general-purpose PLL and gates the system reset on PLL lock.
//  Drives the PLL rst input and reads back its asynchronous locked output.
//  Releases sys_rst only after lock has been stable for a set number of cycles.
//  Re-initialises the PLL on lock timeout or on loss of lock; flags a permanent failure.
// PARAMETERS
//  RST_PULSE_CYCLES    16     refclk cycles pll_rst is held high on each (re)initialisation
//  LOCK_TIMEOUT_CYCLES 50000  max refclk cycles to wait for locked after pll_rst falls (1 ms @ 50 MHz)
//  LOCK_STABLE_CYCLES  1024   consecutive synchronised-locked cycles required before releasing sys_rst
//  MAX_RETRIES         7      timeouts tolerated before FAIL (total attempts = MAX_RETRIES+1); must be <= 7
//  CNT_W               20     shared counter width; must hold the largest of the three cycle parameters
// PORTS
//  refclk         in   1  free-running 50 MHz reference clock; sole clock
//  rst            in   1  reset, asynchronous, active-high
//  pll_locked     in   1  PLL locked output; asynchronous to refclk
//  soft_reset_req in   1  synchronous 1-cycle request; forces full re-initialisation
//  pll_rst        out  1  drives PLL rst; active-high
//  sys_rst        out  1  active-high reset to downstream logic in the PLL output domains
//  lock_ok        out  1  high only in RUN
//  fail           out  1  high only in FAIL
//  loss_of_lock   out  1  1-cycle pulse when lock is lost in RUN
//  retry_count    out  3  number of timeouts in the current sequence
//  state          out  3  encoded FSM state, for debug
// BEHAVIOUR
//  - Reset (rst high, asynchronous):
//    - state=RESET(0), counter=0, retry_count=0
//    - pll_rst=1, sys_rst=1, lock_ok=0, fail=0, loss_of_lock=0
//    - Outputs take these values immediately, without waiting for a clock edge.
//  - pll_locked passes through a 2-flop synchroniser (locked_s); latency 2 cycles. The synchroniser is reset to 0.
//  - All outputs are registered and update on the same edge as state.
//    - pll_rst=1 in RESET and FAIL.
//    - sys_rst=0 only in RUN.
//  - RESET(0): counter increments each cycle.
//    - At counter==RST_PULSE_CYCLES-1: clear counter, go WAIT_LOCK.
//    - pll_rst is high for exactly RST_PULSE_CYCLES cycles.
//  - WAIT_LOCK(1): counter increments each cycle.
//    - locked_s=1: clear counter, go STABLE.
//    - Else, at counter==LOCK_TIMEOUT_CYCLES-1 (timeout):
//      - retry_count==MAX_RETRIES: go FAIL.
//      - Otherwise: retry_count+1, go RESET.
//  - STABLE(2): counter counts consecutive locked_s=1 cycles.
//    - locked_s=0: clear counter, go WAIT_LOCK (fresh timeout window; retry_count unchanged).
//    - counter==LOCK_STABLE_CYCLES-1: go RUN.
//  - RUN(3): sys_rst=0, lock_ok=1.
//    - locked_s=0: loss_of_lock=1 for 1 cycle, clear counter, go RESET.
//    - sys_rst is reasserted on the same edge.
//    - retry_count is not incremented and not cleared.
//  - FAIL(4): terminal. Exit only via rst or soft_reset_req.
//  - soft_reset_req has highest priority in every state (including FAIL and RESET):
//    - go RESET, counter=0, retry_count=0, fail=0, loss_of_lock=0.
//    - In RESET, the pulse restarts its full length.
//  - Simultaneous events:
//    - locked_s=1 on the timeout cycle: lock wins (go STABLE).
//    - soft_reset_req together with loss of lock: no loss_of_lock pulse.
//  - The counter never wraps; every terminal compare is on an exact value, and the counter clears on every state change.
//  - retry_count saturates at MAX_RETRIES.
// TESTING (RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2)
//  1. Clean lock:
//     - Stimulus: release rst; raise pll_locked 5 cycles after pll_rst falls.
//     - Required: pll_rst high exactly 4 cycles; sys_rst falls 2+8(+1) cycles after pll_locked rises; lock_ok=1, retry_count=0.
//  2. Never locks:
//     - Stimulus: pll_locked held at 0.
//     - Required: pll_rst pulses 3 times with 20-cycle gaps, then stays high; fail=1, retry_count=2, sys_rst=1.
//  3. Glitch in STABLE:
//     - Stimulus: pll_locked drops for 1 cycle after 5 stable cycles, then returns.
//     - Required: back to WAIT_LOCK; the 8-cycle stable count restarts; sys_rst release delayed accordingly; retry_count=0.
//  4. Loss in RUN:
//     - Stimulus: drop pll_locked.
//     - Required: loss_of_lock single pulse 3 cycles later, with sys_rst=1 the same cycle; pll_rst 4-cycle pulse; re-lock returns to RUN.
//  5. Recovery from FAIL:
//     - Stimulus: in FAIL, pulse soft_reset_req.
//     - Required: state=RESET, fail=0, retry_count=0, pll_rst high 4 more cycles.
//  6. Asynchronous reset:
//     - Stimulus: assert rst mid-WAIT_LOCK, between clock edges.
//     - Required: pll_rst=1, sys_rst=1, state=0 immediately; sequence restarts cleanly after rst deasserts.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer: pulses pll_rst, waits for a synchronised lock, qualifies it
// for a stable period, then releases sys_rst; retries on timeout and parks in FAIL.
module pll_lock_supervisor #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 7,
  parameter int unsigned CNT_W               = 20
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       soft_reset_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       lock_ok,
  output logic       fail,
  output logic       loss_of_lock,
  output logic [2:0] retry_count,
  output logic [2:0] state
);

  localparam int unsigned RETRY_W = 3;
  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [1:0]         sync_q, sync_d;
  logic               pll_rst_q, pll_rst_d;
  logic               sys_rst_q, sys_rst_d;
  logic               lock_ok_q, lock_ok_d;
  logic               fail_q, fail_d;
  logic               loss_q, loss_d;
  logic               locked_s;

  assign locked_s = sync_q[1];

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RESET;
      cnt_q     <= '0;
      retry_q   <= '0;
      sync_q    <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      lock_ok_q <= 1'b0;
      fail_q    <= 1'b0;
      loss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      sync_q    <= sync_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      lock_ok_q <= lock_ok_d;
      fail_q    <= fail_d;
      loss_q    <= loss_d;
    end
  end

  // Next state; every transition clears the counter so terminal compares stay exact
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = 1'b0;
    sync_d  = {sync_q[0], pll_locked};

    if (soft_reset_req) begin
      state_d = ST_RESET;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        ST_RESET: begin
          if (cnt_q == RST_LAST) begin
            cnt_d   = '0;
            state_d = ST_WAIT_LOCK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            cnt_d   = '0;
            state_d = ST_STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d = '0;
            if (retry_q >= RETRY_MAX) begin
              state_d = ST_FAIL;
            end else begin
              retry_d = retry_q + RETRY_W'(1);
              state_d = ST_RESET;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_STABLE: begin
          if (!locked_s) begin
            cnt_d   = '0;
            state_d = ST_WAIT_LOCK;
          end else if (cnt_q == STABLE_LAST) begin
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!locked_s) begin
            loss_d  = 1'b1;
            cnt_d   = '0;
            state_d = ST_RESET;
          end
        end
        ST_FAIL: begin
          cnt_d = '0;
        end
        default: begin
          cnt_d   = '0;
          state_d = ST_RESET;
        end
      endcase
    end

    pll_rst_d = (state_d == ST_RESET) || (state_d == ST_FAIL);
    sys_rst_d = (state_d != ST_RUN);
    lock_ok_d = (state_d == ST_RUN);
    fail_d    = (state_d == ST_FAIL);
  end

  assign pll_rst      = pll_rst_q;
  assign sys_rst      = sys_rst_q;
  assign lock_ok      = lock_ok_q;
  assign fail         = fail_q;
  assign loss_of_lock = loss_q;
  assign retry_count  = retry_q;
  assign state        = state_q;

endmodule
